// File: rtl/led_serial_out.sv
`default_nettype none
// ============================================================================
// Module      : led_serial_out
// Description : GPIO write register plus a serialiser that pushes the 16-bit
//               LED image out to an external shift-register LED board.
//               A CPU write latches {GPIOf0, LED_out, counter_set} and marks a
//               frame pending; the FSM then clocks 16 bits out MSB first on
//               led_clk/led_sout and pulses LED_PEN to parallel-load the board.
//               A complete frame takes 34*DIV clk cycles.
// Ports       : clk          system clock, rising edge
//               RSTN         asynchronous active-low reset
//               EN           write strobe from the bus decoder
//               P_Data[31:0] write data
//               counter_set  P_Data[1:0] of the last write
//               LED_out      P_Data[17:2] of the last write
//               GPIOf0       P_Data[31:18] of the last write
//               led_clk      serial shift clock to the LED board
//               led_sout     serial data, MSB first
//               LED_PEN      parallel-load enable to the LED board
//               led_clrn     clear-not to the LED board, low during reset
//               busy         high while a frame is in flight
// Parameters  : DIV          clk cycles per led_clk half-period (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module led_serial_out #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        EN,
    input  logic [31:0] P_Data,
    output logic [1:0]  counter_set,
    output logic [15:0] LED_out,
    output logic [13:0] GPIOf0,
    output logic        led_clk,
    output logic        led_sout,
    output logic        LED_PEN,
    output logic        led_clrn,
    output logic        busy
);

    // The divider also times the latch phase (2*DIV cycles, up to 510),
    // so it needs one bit more than DIV itself.
    localparam int              DIV_W      = 9;
    localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [4:0]       LAST_BIT   = 5'd15;
    localparam logic [4:0]       BIT_MAX    = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [31:0]      data_q,    data_d;
    logic             pending_q, pending_d;
    logic [15:0]      shift_q,   shift_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic             phase_q,   phase_d;   // 0 = led_clk low half, 1 = high half
    logic             clrn_q,    clrn_d;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            pending_q <= 1'b1;      // first frame after reset blanks the LEDs
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            phase_q   <= 1'b0;
            clrn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            clrn_q    <= clrn_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        pending_d = pending_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        phase_d   = phase_q;
        clrn_d    = 1'b1;

        // Writes are accepted in every state; the frame in flight works from
        // its own shift register copy, so it is never disturbed.
        if (EN) begin
            data_d    = P_Data;
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    // Load the image that was registered before this edge; a
                    // write landing on this same edge keeps pending set and
                    // produces its own follow-up frame.
                    shift_d   = data_q[17:2];
                    if (!EN) begin
                        pending_d = 1'b0;
                    end
                    bit_cnt_d = '0;
                    div_d     = '0;
                    phase_d   = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (div_q == PHASE_LAST) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // End of the high half: led_clk falls, next bit.
                        phase_d = 1'b0;
                        shift_d = {shift_q[14:0], 1'b0};
                        if (bit_cnt_q != BIT_MAX) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_LATCH;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            ST_LATCH: begin
                if (div_q == LATCH_LAST) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign counter_set = data_q[1:0];
    assign LED_out     = data_q[17:2];
    assign GPIOf0      = data_q[31:18];

    // Serial outputs are decoded from state so that reset clears them at once
    // and no partial LED_PEN pulse can escape an aborted frame.
    assign led_clk  = (state_q == ST_SHIFT) && phase_q;
    assign led_sout = (state_q == ST_SHIFT) && shift_q[15];
    assign LED_PEN  = (state_q == ST_LATCH);
    assign busy     = (state_q != ST_IDLE);
    assign led_clrn = clrn_q;

endmodule
`default_nettype wire

// File: tb/tb_led_serial_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_serial_out
// Description : Self-checking bench for led_serial_out. One instance runs with
//               DIV=4 for the main scenarios, a second with DIV=1 for the
//               fastest divider setting. Register decoding is table driven;
//               frame-level corner cases are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_serial_out;

    logic        clk;
    logic        rstn0, en0, rstn1, en1;
    logic [31:0] pd0, pd1;

    logic [1:0]  cs0, cs1;
    logic [15:0] led0, led1;
    logic [13:0] gpio0, gpio1;
    logic        lclk0, sout0, pen0, clrn0, busy0;
    logic        lclk1, sout1, pen1, clrn1, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    led_serial_out #(.DIV(4)) dut0 (
        .clk(clk), .RSTN(rstn0), .EN(en0), .P_Data(pd0),
        .counter_set(cs0), .LED_out(led0), .GPIOf0(gpio0),
        .led_clk(lclk0), .led_sout(sout0), .LED_PEN(pen0),
        .led_clrn(clrn0), .busy(busy0)
    );

    led_serial_out #(.DIV(1)) dut1 (
        .clk(clk), .RSTN(rstn1), .EN(en1), .P_Data(pd1),
        .counter_set(cs1), .LED_out(led1), .GPIOf0(gpio1),
        .led_clk(lclk1), .led_sout(sout1), .LED_PEN(pen1),
        .led_clrn(clrn1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p_data;
        logic [1:0]  cs;
        logic [15:0] led;
        logic [13:0] gpio;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One-cycle write strobe launched at a falling edge; returns at the
    // falling edge after the write has been registered.
    task automatic do_write(input bit sel, input logic [31:0] data);
        if (sel) begin en1 = 1'b1; pd1 = data; end
        else     begin en0 = 1'b1; pd0 = data; end
        @(negedge clk);
        en0 = 1'b0;
        en1 = 1'b0;
    endtask

    // Follows a frame from the current falling edge (busy already high) to the
    // first falling edge with busy low. Optional writes are injected at the
    // given cycle offsets (-1 disables).
    task automatic capture(input bit sel,
                           input int wr_at1, input logic [31:0] wr_d1,
                           input int wr_at2, input logic [31:0] wr_d2,
                           output logic [15:0] bits, output int nbits,
                           output int pen, output int bcyc,
                           output int bad, output int toggles);
        logic prev_clk, prev_sout, b, c, s, p;
        int cycles;
        bits = '0; nbits = 0; pen = 0; bcyc = 0; bad = 0; toggles = 0;
        prev_clk = 1'b0; prev_sout = 1'b0; cycles = 0;
        b = sel ? busy1 : busy0;
        while (b && cycles < 1000) begin
            c = sel ? lclk1 : lclk0;
            s = sel ? sout1 : sout0;
            p = sel ? pen1  : pen0;
            if (c && !prev_clk) begin
                bits  = {bits[14:0], s};
                nbits++;
            end
            if (c && prev_clk && (s != prev_sout)) bad++;
            if (p && c) bad++;
            if (p) pen++;
            if (c != prev_clk) toggles++;
            prev_clk  = c;
            prev_sout = s;
            if (cycles == wr_at1 || cycles == wr_at2) begin
                if (sel) begin en1 = 1'b1; pd1 = (cycles == wr_at1) ? wr_d1 : wr_d2; end
                else     begin en0 = 1'b1; pd0 = (cycles == wr_at1) ? wr_d1 : wr_d2; end
            end else begin
                en0 = 1'b0;
                en1 = 1'b0;
            end
            bcyc++;
            cycles++;
            @(negedge clk);
            b = sel ? busy1 : busy0;
        end
        en0 = 1'b0;
        en1 = 1'b0;
        check("frame_ends_in_bound", 64'(cycles < 1000), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [4];
        logic [15:0] bits;
        int          nbits, pen, bcyc, bad, tog, rises;
        logic        prev_b;

        // P_Data[17:2] of 32'hFFFF_AAA9 is 16'hEAAA (bits 17:16 are both 1).
        vecs[0] = '{32'hFFFF_AAA9, 2'b01, 16'hEAAA, 14'h3FFF};
        vecs[1] = '{32'h5554_48D2, 2'b10, 16'h1234, 14'h1555};
        vecs[2] = '{32'h0002_0007, 2'b11, 16'h8001, 14'h0000};
        vecs[3] = '{32'hAAAB_FFFC, 2'b00, 16'hFFFF, 14'h2AAA};

        rstn0 = 1'b0; rstn1 = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        pd0 = '0; pd1 = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("reset_outputs", {27'd0, cs0, led0, gpio0, lclk0, sout0, pen0, busy0}, 64'd0);
        check("reset_clrn", 64'(clrn0), 64'd0);

        // ---------------- first frame after reset is all zeros ----------------
        rstn0 = 1'b1;
        @(negedge clk);
        check("clrn_after_release", 64'(clrn0), 64'd1);
        check("busy_after_release", 64'(busy0), 64'd1);
        capture(1'b0, -1, '0, -1, '0, bits, nbits, pen, bcyc, bad, tog);
        check("zero_frame_bits", 64'(bits), 64'h0);
        check("zero_frame_nbits", 64'(nbits), 64'd16);
        check("zero_frame_pen", 64'(pen), 64'd8);
        check("zero_frame_busy", 64'(bcyc), 64'd136);

        // ---------------- table-driven writes in IDLE ----------------
        for (int i = 0; i < 4; i++) begin
            do_write(1'b0, vecs[i].p_data);
            check($sformatf("v%0d_counter_set", i), 64'(cs0), 64'(vecs[i].cs));
            check($sformatf("v%0d_led_out", i), 64'(led0), 64'(vecs[i].led));
            check($sformatf("v%0d_gpiof0", i), 64'(gpio0), 64'(vecs[i].gpio));
            check($sformatf("v%0d_busy_before_load", i), 64'(busy0), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_busy_after_load", i), 64'(busy0), 64'd1);
            capture(1'b0, -1, '0, -1, '0, bits, nbits, pen, bcyc, bad, tog);
            check($sformatf("v%0d_bits", i), 64'(bits), 64'(vecs[i].led));
            check($sformatf("v%0d_nbits", i), 64'(nbits), 64'd16);
            check($sformatf("v%0d_pen", i), 64'(pen), 64'd8);
            check($sformatf("v%0d_busy_cycles", i), 64'(bcyc), 64'd136);
            check($sformatf("v%0d_sout_stable", i), 64'(bad), 64'd0);
        end

        // ---------------- two writes during a frame collapse ----------------
        do_write(1'b0, 32'h0001_6968);          // LED 16'h5A5A
        @(negedge clk);
        capture(1'b0, 20, 32'h0000_48D0, 60, 32'h0000_03FC, bits, nbits, pen, bcyc, bad, tog);
        check("mid_frame_bits_unchanged", 64'(bits), 64'h5A5A);
        check("mid_frame_busy_cycles", 64'(bcyc), 64'd136);
        check("mid_frame_latest_led", 64'(led0), 64'h00FF);
        check("mid_frame_idle_gap", 64'(busy0), 64'd0);
        @(negedge clk);
        check("followup_started", 64'(busy0), 64'd1);
        capture(1'b0, -1, '0, -1, '0, bits, nbits, pen, bcyc, bad, tog);
        check("followup_bits", 64'(bits), 64'h00FF);
        rises = 0;
        prev_b = busy0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy0 && !prev_b) rises++;
            prev_b = busy0;
        end
        check("single_followup", 64'(rises), 64'd0);

        // ---------------- write on the exact IDLE load edge ----------------
        en0 = 1'b1; pd0 = 32'h0000_F0F0;        // LED 16'h3C3C
        @(negedge clk);
        en0 = 1'b1; pd0 = 32'h0002_9694;        // LED 16'hA5A5, lands on load edge
        @(negedge clk);
        en0 = 1'b0;
        check("load_edge_busy", 64'(busy0), 64'd1);
        capture(1'b0, -1, '0, -1, '0, bits, nbits, pen, bcyc, bad, tog);
        check("load_edge_first_bits", 64'(bits), 64'h3C3C);
        check("load_edge_gap", 64'(busy0), 64'd0);
        @(negedge clk);
        check("load_edge_second_start", 64'(busy0), 64'd1);
        capture(1'b0, -1, '0, -1, '0, bits, nbits, pen, bcyc, bad, tog);
        check("load_edge_second_bits", 64'(bits), 64'hA5A5);

        // ---------------- reset in the middle of bit 7 ----------------
        do_write(1'b0, 32'h0003_FFFC);          // LED 16'hFFFF
        @(negedge clk);
        repeat (58) @(negedge clk);
        check("pre_reset_sout", 64'(sout0), 64'd1);
        @(posedge clk);
        #2 rstn0 = 1'b0;
        #1;
        check("async_reset_outputs", {27'd0, cs0, led0, gpio0, lclk0, sout0, pen0, busy0}, 64'd0);
        check("async_reset_clrn", 64'(clrn0), 64'd0);
        repeat (2) @(negedge clk);
        check("held_reset_pen", 64'(pen0), 64'd0);
        rstn0 = 1'b1;
        @(negedge clk);
        check("rereset_clrn", 64'(clrn0), 64'd1);
        capture(1'b0, -1, '0, -1, '0, bits, nbits, pen, bcyc, bad, tog);
        check("rereset_zero_bits", 64'(bits), 64'h0);
        check("rereset_busy_cycles", 64'(bcyc), 64'd136);

        // ---------------- DIV=1 instance ----------------
        check("div1_reset_clrn", 64'(clrn1), 64'd0);
        rstn1 = 1'b1;
        @(negedge clk);
        capture(1'b1, -1, '0, -1, '0, bits, nbits, pen, bcyc, bad, tog);
        check("div1_busy_cycles", 64'(bcyc), 64'd34);
        check("div1_pen", 64'(pen), 64'd2);
        check("div1_toggles", 64'(tog), 64'd32);
        check("div1_zero_bits", 64'(bits), 64'h0);
        do_write(1'b1, 32'h0003_0E94);          // LED 16'hC3A5
        @(negedge clk);
        capture(1'b1, -1, '0, -1, '0, bits, nbits, pen, bcyc, bad, tog);
        check("div1_bits", 64'(bits), 64'hC3A5);
        check("div1_nbits", 64'(nbits), 64'd16);
        check("div1_frame_cycles", 64'(bcyc), 64'd34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
